// File: rtl/line_clear_scanner_pkg.sv
// -----------------------------------------------------------------------------
// line_clear_scanner_pkg
// Shared board geometry, mode encodings, scanner state encoding and the
// combo scoring helper used by the line-clear scanner and its bench.
// -----------------------------------------------------------------------------
package line_clear_scanner_pkg;

    // Board geometry: BLOCKS_ROW cells per row, BLOCKS_COL rows, row 0 on top.
    localparam int BLOCKS_ROW = 8;
    localparam int BLOCKS_COL = 16;
    localparam int BITS_Y_POS = 4;

    // Per-player mode as reported by the game control block.
    localparam int MODE_BITS = 3;
    localparam logic [MODE_BITS-1:0] MODE_IDLE  = 3'd0;
    localparam logic [MODE_BITS-1:0] MODE_PLAY  = 3'd1;
    localparam logic [MODE_BITS-1:0] MODE_SHIFT = 3'd2;
    localparam logic [MODE_BITS-1:0] MODE_GET   = 3'd3;
    localparam logic [MODE_BITS-1:0] MODE_PAUSE = 3'd4;
    localparam logic [MODE_BITS-1:0] MODE_OVER  = 3'd5;

    // Pending-attack counter and display counters.
    localparam int ATK_BITS   = 3;
    localparam int ATK_MAX    = 7;
    localparam int SCORE_BITS = 16;
    localparam int LINES_BITS = 8;

    typedef enum logic [1:0] {
        LCS_IDLE  = 2'd0,
        LCS_SCAN  = 2'd1,
        LCS_ISSUE = 2'd2,
        LCS_WAIT  = 2'd3
    } lcs_state_e;

    // combo holds the number of earlier clears in the current combo,
    // saturated at 3, so the k-th clear scores 1, 2, 4, then 8 forever.
    function automatic logic [SCORE_BITS-1:0] combo_points(input logic [1:0] combo);
        return SCORE_BITS'(1) << combo;
    endfunction

endpackage

// File: rtl/line_clear_scanner_if.sv
// -----------------------------------------------------------------------------
// line_clear_scanner_if
// Bundles the scanner's connection to the game control block, the opponent
// and the display.
//   master : the scanner  (reads mode/board/get_line/opp_mode,
//                          drives remove_row_*, send_en, lines_cleared, score)
//   slave  : the control-block / display side (opposite directions)
// -----------------------------------------------------------------------------
interface line_clear_scanner_if;
    import line_clear_scanner_pkg::*;

    logic [MODE_BITS-1:0]             mode;
    logic [BLOCKS_ROW*BLOCKS_COL-1:0] game_board;
    logic [BITS_Y_POS-1:0]            get_line;
    logic [MODE_BITS-1:0]             opp_mode;
    logic                             remove_row_en;
    logic [BITS_Y_POS-1:0]            remove_row_y;
    logic                             send_en;
    logic [LINES_BITS-1:0]            lines_cleared;
    logic [SCORE_BITS-1:0]            score;

    modport master (
        input  mode, game_board, get_line, opp_mode,
        output remove_row_en, remove_row_y, send_en, lines_cleared, score
    );

    modport slave (
        output mode, game_board, get_line, opp_mode,
        input  remove_row_en, remove_row_y, send_en, lines_cleared, score
    );

endinterface

// File: rtl/line_clear_scanner_attack_counter.sv
// -----------------------------------------------------------------------------
// line_clear_scanner_attack_counter
// Saturating up/down counter of attacks pending toward the opponent.
//   clk, rst   : clock, asynchronous active-high reset
//   state_rst  : synchronous round reset (same effect as rst)
//   inc        : one cleared row this cycle
//   opp_mode   : opponent mode; a rising edge into MODE_GET consumes one attack
//   send_en    : at least one attack pending
// -----------------------------------------------------------------------------
module line_clear_scanner_attack_counter
    import line_clear_scanner_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 state_rst,
    input  logic                 inc,
    input  logic [MODE_BITS-1:0] opp_mode,
    output logic                 send_en
);

    localparam logic [ATK_BITS-1:0] ATK_MAX_V = ATK_BITS'(ATK_MAX);

    logic [ATK_BITS-1:0] count_q, count_d;
    logic                opp_get_q, opp_get_d;
    logic                dec;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        opp_get_d = (opp_mode == MODE_GET);
        dec       = opp_get_d && !opp_get_q;
        count_d   = count_q;

        // Simultaneous clear and consumption cancel out.
        if (inc && !dec) begin
            if (count_q != ATK_MAX_V) count_d = count_q + ATK_BITS'(1);
        end else if (dec && !inc) begin
            if (count_q != '0) count_d = count_q - ATK_BITS'(1);
        end

        if (state_rst) begin
            count_d   = '0;
            opp_get_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values, independent of statement order.
        if (rst) begin
            count_q   <= '0;
            opp_get_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            opp_get_q <= opp_get_d;
        end
    end

    assign send_en = (count_q != '0);

endmodule

// File: rtl/line_clear_scanner.sv
// -----------------------------------------------------------------------------
// line_clear_scanner
// Scans the settled board bottom-up one row per cycle (skipping garbage rows),
// requests removal of each full row from the control block, waits for the
// shift, and keeps lines-cleared, combo score and pending attacks.
//   clk, rst   : clock, asynchronous active-high reset
//   state_rst  : synchronous round reset (same effect as rst)
//   bus        : line_clear_scanner_if.master (mode, board, get_line,
//                opp_mode in; remove_row_en/y, send_en, lines_cleared, score out)
// -----------------------------------------------------------------------------
module line_clear_scanner
    import line_clear_scanner_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 state_rst,
    line_clear_scanner_if.master bus
);

    localparam int ROW_W  = BLOCKS_ROW;
    localparam int COL_H  = BLOCKS_COL;
    localparam int Y_BITS = BITS_Y_POS;

    localparam logic [Y_BITS-1:0] PTR_RESET = Y_BITS'(COL_H - 1);

    lcs_state_e             state_q, state_d;
    logic [Y_BITS-1:0]      ptr_q, ptr_d;
    logic                   remove_row_en_q, remove_row_en_d;
    logic [Y_BITS-1:0]      remove_row_y_q, remove_row_y_d;
    logic [LINES_BITS-1:0]  lines_q, lines_d;
    logic [SCORE_BITS-1:0]  score_q, score_d;
    logic [1:0]             combo_q, combo_d;

    logic                   row_full;
    logic [Y_BITS-1:0]      start_ptr;
    logic [SCORE_BITS:0]    score_sum;
    logic                   atk_inc;

    // Garbage rows sit at the bottom and can never be full, so start above them.
    assign start_ptr = PTR_RESET - bus.get_line;
    assign row_full  = &bus.game_board[int'(ptr_q)*ROW_W +: ROW_W];
    assign score_sum = {1'b0, score_q} + {1'b0, combo_points(combo_q)};

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        remove_row_en_d = remove_row_en_q;
        remove_row_y_d  = remove_row_y_q;
        lines_d         = lines_q;
        score_d         = score_q;
        combo_d         = combo_q;
        atk_inc         = 1'b0;

        unique case (state_q)
            LCS_IDLE: begin
                if (bus.mode == MODE_PLAY) begin
                    state_d = LCS_SCAN;
                    ptr_d   = start_ptr;
                end
            end

            LCS_SCAN: begin
                if (bus.mode != MODE_PLAY) begin
                    state_d = LCS_IDLE;
                end else if (row_full) begin
                    state_d         = LCS_ISSUE;
                    remove_row_en_d = 1'b1;
                    remove_row_y_d  = ptr_q;
                end else if (ptr_q == '0) begin
                    // A whole pass without a full row ends the combo.
                    state_d = LCS_IDLE;
                    combo_d = '0;
                end else begin
                    ptr_d = ptr_q - Y_BITS'(1);
                end
            end

            LCS_ISSUE: begin
                // The control block only takes the request when it has nothing
                // more urgent, so hold it until mode leaves PLAY; a move into
                // SHIFT is the acknowledge, anything else abandons the clear.
                if (bus.mode != MODE_PLAY) begin
                    remove_row_en_d = 1'b0;
                    if (bus.mode == MODE_SHIFT) begin
                        state_d = LCS_WAIT;
                        lines_d = lines_q + LINES_BITS'(1);
                        atk_inc = 1'b1;
                        score_d = score_sum[SCORE_BITS] ? '1 : score_sum[SCORE_BITS-1:0];
                        combo_d = (combo_q == 2'd3) ? combo_q : combo_q + 2'd1;
                    end else begin
                        state_d = LCS_IDLE;
                    end
                end
            end

            LCS_WAIT: begin
                // Rows above the cleared one moved down; rescan from the bottom.
                if (bus.mode == MODE_PLAY) state_d = LCS_IDLE;
            end
        endcase

        if (state_rst) begin
            state_d         = LCS_IDLE;
            ptr_d           = PTR_RESET;
            remove_row_en_d = 1'b0;
            remove_row_y_d  = '0;
            lines_d         = '0;
            score_d         = '0;
            combo_d         = '0;
            atk_inc         = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= LCS_IDLE;
            ptr_q           <= PTR_RESET;
            remove_row_en_q <= 1'b0;
            remove_row_y_q  <= '0;
            lines_q         <= '0;
            score_q         <= '0;
            combo_q         <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            remove_row_en_q <= remove_row_en_d;
            remove_row_y_q  <= remove_row_y_d;
            lines_q         <= lines_d;
            score_q         <= score_d;
            combo_q         <= combo_d;
        end
    end

    line_clear_scanner_attack_counter u_attack_counter (
        .clk       (clk),
        .rst       (rst),
        .state_rst (state_rst),
        .inc       (atk_inc),
        .opp_mode  (bus.opp_mode),
        .send_en   (bus.send_en)
    );

    assign bus.remove_row_en = remove_row_en_q;
    assign bus.remove_row_y  = remove_row_y_q;
    assign bus.lines_cleared = lines_q;
    assign bus.score         = score_q;

endmodule

// File: tb/tb_line_clear_scanner.sv
// -----------------------------------------------------------------------------
// tb_line_clear_scanner
// Directed bench for line_clear_scanner. Expected clear rows go into a queue
// when a full row is planted and are popped when the request appears; counts,
// score and attacks come from a small independent model.
// -----------------------------------------------------------------------------
module tb_line_clear_scanner;
    import line_clear_scanner_pkg::*;

    localparam int ROW_W = BLOCKS_ROW;
    localparam int COL_H = BLOCKS_COL;

    logic clk = 1'b0;
    logic rst;
    logic state_rst;

    line_clear_scanner_if bus();

    line_clear_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .state_rst (state_rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    int exp_y_q[$];
    int exp_lines = 0;
    int exp_score = 0;
    int exp_combo = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_compared++;
        assert (obs === expv) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_row(input int y, input logic [ROW_W-1:0] v);
        bus.game_board[y*ROW_W +: ROW_W] = v;
    endtask

    // Emulates the control block removing row y: rows above drop by one.
    task automatic shift_down(input int y);
        for (int r = y; r > 0; r--)
            bus.game_board[r*ROW_W +: ROW_W] = bus.game_board[(r-1)*ROW_W +: ROW_W];
        bus.game_board[0 +: ROW_W] = '0;
    endtask

    task automatic wait_req(input string tag, output int lat);
        int exp_y;
        lat = 0;
        while (bus.remove_row_en !== 1'b1 && lat < 40) begin
            tick(1);
            lat++;
        end
        check({tag, " req"}, 32'(bus.remove_row_en), 32'd1);
        exp_y = -1;
        if (exp_y_q.size() != 0) exp_y = exp_y_q.pop_front();
        check({tag, " y"}, 32'(bus.remove_row_y), exp_y);
    endtask

    task automatic request(input int y, input string tag, output int lat);
        bus.mode = MODE_IDLE;
        tick(2);
        set_row(y, '1);
        exp_y_q.push_back(y);
        bus.mode = MODE_PLAY;
        wait_req(tag, lat);
    endtask

    task automatic ack(input int y, input logic opp_get);
        bus.mode = MODE_SHIFT;
        if (opp_get) bus.opp_mode = MODE_GET;
        tick(1);
        exp_lines = (exp_lines + 1) % 256;
        exp_score = exp_score + (1 << exp_combo);
        if (exp_score > 65535) exp_score = 65535;
        if (exp_combo < 3) exp_combo++;
        bus.opp_mode = MODE_IDLE;
        shift_down(y);
        tick(1);
        bus.mode = MODE_PLAY;
        tick(2);
    endtask

    task automatic get_edge();
        bus.opp_mode = MODE_GET;
        tick(1);
        bus.opp_mode = MODE_IDLE;
        tick(1);
    endtask

    task automatic empty_pass();
        bus.mode = MODE_PLAY;
        tick(COL_H + 4);
        exp_combo = 0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, " lines"}, 32'(bus.lines_cleared), exp_lines);
        check({tag, " score"}, 32'(bus.score), exp_score);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " en"},    32'(bus.remove_row_en), 32'd0);
        check({tag, " y"},     32'(bus.remove_row_y),  32'd0);
        check({tag, " send"},  32'(bus.send_en),       32'd0);
        check({tag, " lines"}, 32'(bus.lines_cleared), 32'd0);
        check({tag, " score"}, 32'(bus.score),         32'd0);
    endtask

    initial begin
        int lat;
        int bad;

        rst            = 1'b1;
        state_rst      = 1'b0;
        bus.mode       = MODE_IDLE;
        bus.game_board = '0;
        bus.get_line   = '0;
        bus.opp_mode   = MODE_IDLE;
        tick(2);
        check_zero("reset");
        rst = 1'b0;
        tick(1);

        // Single clear of the bottom row.
        request(15, "t1", lat);
        check("t1 latency", lat, 32'd2);
        ack(15, 1'b0);
        check_counts("t1");
        check("t1 send", 32'(bus.send_en), 32'd1);
        check("t1 en low", 32'(bus.remove_row_en), 32'd0);
        empty_pass();

        // Two full rows: the upper one moves down after the first shift.
        bus.mode = MODE_IDLE;
        tick(2);
        set_row(14, '1);
        set_row(10, '1);
        exp_y_q.push_back(14);
        bus.mode = MODE_PLAY;
        wait_req("t2a", lat);
        ack(14, 1'b0);
        exp_y_q.push_back(11);
        wait_req("t2b", lat);
        ack(11, 1'b0);
        check_counts("t2");
        empty_pass();

        // Acknowledge held off for 20 cycles.
        request(5, "t3", lat);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.remove_row_en !== 1'b1 || bus.remove_row_y !== 4'd5) bad++;
        end
        check("t3 held", bad, 32'd0);
        ack(5, 1'b0);
        check_counts("t3");
        empty_pass();

        // Pause while the request is up: dropped, nothing counted.
        request(7, "t4", lat);
        bus.mode = MODE_PAUSE;
        tick(1);
        check("t4 en", 32'(bus.remove_row_en), 32'd0);
        check_counts("t4");
        set_row(7, '0);
        empty_pass();
        // Four attacks pending (t1, t2 x2, t3); the pause added none.
        repeat (3) get_edge();
        check("t4 drain3 send", 32'(bus.send_en), 32'd1);
        get_edge();
        check("t4 drain4 send", 32'(bus.send_en), 32'd0);

        // Nine clears saturate the counter at 7.
        for (int i = 0; i < 9; i++) begin
            request(15, "t5", lat);
            ack(15, 1'b0);
        end
        check_counts("t5");
        check("t5 sat send", 32'(bus.send_en), 32'd1);
        empty_pass();
        repeat (3) get_edge();
        // Clear and opponent GET edge together: counter stays at 4.
        request(15, "t5 same", lat);
        ack(15, 1'b1);
        empty_pass();
        repeat (3) get_edge();
        check("t5 left1 send", 32'(bus.send_en), 32'd1);
        get_edge();
        check("t5 left0 send", 32'(bus.send_en), 32'd0);
        get_edge();
        check("t5 floor send", 32'(bus.send_en), 32'd0);
        empty_pass();
        request(15, "t5 floor", lat);
        ack(15, 1'b0);
        check("t5 after floor send", 32'(bus.send_en), 32'd1);
        get_edge();
        check("t5 after floor drain", 32'(bus.send_en), 32'd0);
        check_counts("t5 end");

        // Asynchronous reset in the middle of a request.
        request(15, "t6", lat);
        #2;
        rst = 1'b1;
        #1;
        check_zero("t6 async");
        exp_lines = 0;
        exp_score = 0;
        exp_combo = 0;
        exp_y_q.delete();
        bus.mode = MODE_IDLE;
        set_row(15, '0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);

        // Three garbage rows (drawn full) must be skipped.
        bus.get_line = 4'd3;
        for (int r = 12; r < 16; r++) set_row(r, '1);
        exp_y_q.push_back(12);
        bus.mode = MODE_PLAY;
        wait_req("t6 garbage", lat);
        check("t6 garbage latency", lat, 32'd2);
        ack(12, 1'b0);
        check_counts("t6");

        // Round reset, then the next pass starts at row 12 again.
        set_row(12, '1);
        state_rst = 1'b1;
        tick(1);
        check_zero("t6 state_rst");
        state_rst = 1'b0;
        exp_y_q.push_back(12);
        wait_req("t6 rescan", lat);
        check("t6 rescan latency", lat, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
